// File: rtl/maze_pkg.sv
// maze_pkg: shared constants, FSM state type and the rectangle test used by
// the maze overlay and its collision scanner.
//   SCREEN_W x SCREEN_H  OLED raster size (96 x 64)
//   SPRITE_SZ            player square edge length (9)
//   START_X / START_Y    player position after reset (3, 40)
//   COL_*                RGB565 colours with special meaning in the maze
//   state_t              move FSM states
package maze_pkg;

    localparam int SCREEN_W  = 96;
    localparam int SCREEN_H  = 64;
    localparam int SPRITE_SZ = 9;
    localparam int START_X   = 3;
    localparam int START_Y   = 40;

    localparam logic [15:0] COL_PLAYER = 16'h001F;
    localparam logic [15:0] COL_WALL   = 16'hFFFF;
    localparam logic [15:0] COL_BLACK  = 16'h0000;

    // Last in-frame scan index; anything above it is a wrapped/blank index.
    localparam logic [12:0] LAST_IDX = 13'(SCREEN_W * SCREEN_H - 1);

    // Largest top-left corner that keeps the whole sprite on screen.
    localparam logic [6:0] MAX_X = 7'(SCREEN_W - SPRITE_SZ);
    localparam logic [5:0] MAX_Y = 6'(SCREEN_H - SPRITE_SZ);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        SCAN   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    // True when pixel (px, py) lies inside the SPRITE_SZ square at (rx, ry).
    function automatic logic in_rect(input logic [6:0] px, input logic [5:0] py,
                                     input logic [6:0] rx, input logic [5:0] ry);
        logic [7:0] dx;
        logic [6:0] dy;
        dx = {1'b0, px} - {1'b0, rx};
        dy = {1'b0, py} - {1'b0, ry};
        return (px >= rx) && (py >= ry) &&
               (dx < 8'(SPRITE_SZ)) && (dy < 7'(SPRITE_SZ));
    endfunction

endpackage

// File: rtl/maze_overlay_if.sv
// maze_overlay_if: pixel stream, button pulses and player status of the
// maze overlay.
//   pixel_index  scan index 0..6143 (x = idx % 96, y = idx / 96)
//   maze_data    RGB565 maze pixel, one cycle behind its pixel_index
//   btn_*        single-cycle debounced move pulses
//   pixel_data   composited RGB565 pixel, two cycles behind pixel_index
//   player_x/y   sprite top-left corner
//   move_busy    a move is being checked against a frame
//   win          sticky goal flag
// master = pixel/button source, slave = the overlay.
interface maze_overlay_if;
    logic [12:0] pixel_index;
    logic [15:0] maze_data;
    logic        btn_up;
    logic        btn_down;
    logic        btn_left;
    logic        btn_right;
    logic [15:0] pixel_data;
    logic [6:0]  player_x;
    logic [5:0]  player_y;
    logic        move_busy;
    logic        win;

    modport master (
        output pixel_index, maze_data, btn_up, btn_down, btn_left, btn_right,
        input  pixel_data, player_x, player_y, move_busy, win
    );

    modport slave (
        input  pixel_index, maze_data, btn_up, btn_down, btn_left, btn_right,
        output pixel_data, player_x, player_y, move_busy, win
    );
endinterface

// File: rtl/maze_collide_scan.sv
// maze_collide_scan: accumulates, over one frame, whether any wall pixel
// falls inside the candidate sprite rectangle.
//   clk, reset        clock, async active-high reset
//   pix_x, pix_y      aligned pixel coordinate
//   pix_vld           aligned index is inside the frame
//   maze_data         maze pixel for that coordinate
//   cand_x, cand_y    candidate top-left corner
//   clear             first pixel of the frame: restart with this pixel only
//   scan_en           keep accumulating
//   collide           a wall was seen inside the candidate
module maze_collide_scan
    import maze_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  pix_x,
    input  logic [5:0]  pix_y,
    input  logic        pix_vld,
    input  logic [15:0] maze_data,
    input  logic [6:0]  cand_x,
    input  logic [5:0]  cand_y,
    input  logic        clear,
    input  logic        scan_en,
    output logic        collide
);
    logic hit;

    assign hit = pix_vld && (maze_data == COL_WALL) &&
                 in_rect(pix_x, pix_y, cand_x, cand_y);

    // clear also folds in the current pixel so index 0 is not lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            collide <= 1'b0;
        else if (clear)
            collide <= hit;
        else if (scan_en)
            collide <= collide | hit;
    end
endmodule

// File: rtl/maze_overlay.sv
// maze_overlay: draws the 9x9 player sprite over the maze stream and moves
// the player one pixel per button pulse after a full-frame wall check.
//   clk, reset  clock, async active-high reset
//   bus         maze_overlay_if.slave (pixel stream, buttons, status)
// Optional build macro MAZE_OVERLAY_GOAL_EN: sticky win flag when a move
// lands on row 0; without it win is constant 0.
module maze_overlay
    import maze_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    maze_overlay_if.slave bus
);
    state_t      state, state_nx;
    logic [12:0] idx_p1;
    logic        vld_p1;
    logic [6:0]  pix_x;
    logic [5:0]  pix_y;
    logic [15:0] pix_p2;
    logic [6:0]  player_x, cand_x, step_x;
    logic [5:0]  player_y, cand_y, step_y;
    logic        step_ok, latch, clear, scan_en, commit, collide, in_sprite;

    // Stage p1: index aligned with maze_data
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            idx_p1 <= '0;
        else
            idx_p1 <= bus.pixel_index;
    end

    // Wrapped indices are outside every rectangle.
    assign vld_p1    = (idx_p1 <= LAST_IDX);
    assign pix_x     = 7'(idx_p1 % 13'(SCREEN_W));
    assign pix_y     = 6'(idx_p1 / 13'(SCREEN_W));
    assign in_sprite = vld_p1 && in_rect(pix_x, pix_y, player_x, player_y);

    // Stage p2: composited output pixel
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pix_p2 <= COL_BLACK;
        else if (in_sprite)
            pix_p2 <= COL_PLAYER;
        else if (bus.maze_data == COL_PLAYER)
            pix_p2 <= COL_BLACK;   // hide the player baked into the maze image
        else
            pix_p2 <= bus.maze_data;
    end

    assign bus.pixel_data = pix_p2;

    // One-pixel step, up > down > left > right; step_ok low means off-screen.
    always_comb begin
        step_x  = player_x;
        step_y  = player_y;
        step_ok = 1'b0;
        if (bus.btn_up) begin
            step_y  = player_y - 6'd1;
            step_ok = (player_y != 6'd0);
        end else if (bus.btn_down) begin
            step_y  = player_y + 6'd1;
            step_ok = (player_y < MAX_Y);
        end else if (bus.btn_left) begin
            step_x  = player_x - 7'd1;
            step_ok = (player_x != 7'd0);
        end else if (bus.btn_right) begin
            step_x  = player_x + 7'd1;
            step_ok = (player_x < MAX_X);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        latch    = 1'b0;
        clear    = 1'b0;
        scan_en  = 1'b0;
        commit   = 1'b0;
        case (state)
            IDLE: begin
                if (step_ok) begin
                    latch    = 1'b1;
                    state_nx = ARM;
                end
            end
            ARM: begin
                // Start only on a frame boundary so the scan sees a whole frame.
                if (idx_p1 == 13'd0) begin
                    clear    = 1'b1;
                    state_nx = SCAN;
                end
            end
            SCAN: begin
                scan_en = 1'b1;
                if (idx_p1 == LAST_IDX)
                    state_nx = COMMIT;
            end
            COMMIT: begin
                commit   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.move_busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (latch) begin
            cand_x <= step_x;
            cand_y <= step_y;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            player_x <= 7'(START_X);
            player_y <= 6'(START_Y);
        end else if (commit && !collide) begin
            player_x <= cand_x;
            player_y <= cand_y;
        end
    end

    assign bus.player_x = player_x;
    assign bus.player_y = player_y;

    maze_collide_scan u_scan (
        .clk       (clk),
        .reset     (reset),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_vld   (vld_p1),
        .maze_data (bus.maze_data),
        .cand_x    (cand_x),
        .cand_y    (cand_y),
        .clear     (clear),
        .scan_en   (scan_en),
        .collide   (collide)
    );

`ifdef MAZE_OVERLAY_GOAL_EN
    logic win_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            win_q <= 1'b0;
        else if (commit && !collide && (cand_y == 6'd0))
            win_q <= 1'b1;
    end

    assign bus.win = win_q;
`else
    assign bus.win = 1'b0;
`endif
endmodule
